// File: rtl/if_inst_buffer.sv
// if_inst_buffer: instruction FIFO between IF1 and ID.
// Holds up to DEPTH fetched instructions with their PC and branch
// prediction. flush discards everything (branch mispredict or exception
// redirect). Optional feature macro: IF_BUF_BYPASS_EN. It lets an
// instruction arriving at an empty buffer go straight to ID in the same
// cycle. Without it, every entry takes one cycle from push to out_valid.
module if_inst_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  input  logic          in_pre_branch,
  input  logic [31:0]   in_pre_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic          out_pre_branch,
  output logic [31:0]   out_pre_pc,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  // Entry storage, one array per field.
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic        pb_mem   [DEPTH];
  logic [31:0] ppc_mem  [DEPTH];

  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [AW:0]   count_q;

  logic empty;
  logic full;
  logic bypass_hit;
  logic push;
  logic pop;

  // Occupancy flags and handshake.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_CNT);
    // Full blocks input even when ID pops in the same cycle.
    in_ready = !full && !flush && !rst;
`ifdef IF_BUF_BYPASS_EN
    bypass_hit = empty && in_valid && !flush && !rst;
`else
    bypass_hit = 1'b0;
`endif
    out_valid = (!empty && !flush) || bypass_hit;
    // A bypassed instruction taken by ID is never stored.
    push = in_valid && in_ready && !(bypass_hit && out_ready);
    // Nothing stored to pop while bypassing.
    pop  = out_valid && out_ready && !bypass_hit;
  end

  // Head entry (or the incoming instruction when bypassing) to ID.
  always_comb begin
    out_pc         = pc_mem[head_q];
    out_inst       = inst_mem[head_q];
    out_pre_branch = pb_mem[head_q];
    out_pre_pc     = ppc_mem[head_q];
    if (bypass_hit) begin
      out_pc         = in_pc;
      out_inst       = in_inst;
      out_pre_branch = in_pre_branch;
      out_pre_pc     = in_pre_pc;
    end
  end

  assign count = count_q;

  // Pointers and occupancy; flush outranks push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + AW'(1);
      end
      if (pop) begin
        head_q <= head_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry write at the tail; reset clears storage so out_* read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
        pb_mem[i]   <= 1'b0;
        ppc_mem[i]  <= '0;
      end
    end else if (push) begin
      pc_mem[tail_q]   <= in_pc;
      inst_mem[tail_q] <= in_inst;
      pb_mem[tail_q]   <= in_pre_branch;
      ppc_mem[tail_q]  <= in_pre_pc;
    end
  end

endmodule

// File: doc/if_inst_buffer.md
IF_INST_BUFFER -- requirements
Module: if_inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 2, pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port flush  input  1  discard all entries (branch mispredict or exception redirect).
REQ-006 SHALL have port in_valid  input  1  IF1 presents a fetched instruction.
REQ-007 SHALL have port in_ready  output  1  buffer accepts an entry this cycle.
REQ-008 SHALL have port in_pc  input  32  PC of the fetched instruction.
REQ-009 SHALL have port in_inst  input  32  instruction word from ICache.
REQ-010 SHALL have port in_pre_branch  input  1  IF1 predicted taken.
REQ-011 SHALL have port in_pre_pc  input  32  IF1 predicted target PC.
REQ-012 SHALL have port out_valid  output  1  head entry available to ID.
REQ-013 SHALL have port out_ready  input  1  ID consumes the head entry this cycle.
REQ-014 SHALL have ports out_pc / out_inst / out_pre_branch / out_pre_pc  output  32/32/1/32  head-entry fields.
REQ-015 SHALL have port count  output  AW+1  number of valid entries, 0..DEPTH.

Function
REQ-016 Push SHALL occur on an edge where in_valid & in_ready; the entry is written at the tail and the tail pointer advances modulo DEPTH.
REQ-017 Pop SHALL occur on an edge where out_valid & out_ready; the head pointer advances modulo DEPTH.
REQ-018 in_ready SHALL be 1 iff count < DEPTH, flush = 0 and rst = 0; it SHALL NOT depend on out_ready (no push when full, even with a simultaneous pop).
REQ-019 out_valid SHALL be 1 iff count != 0 and flush = 0; out_* SHALL be driven combinationally from the head entry.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-021 count SHALL increment on push-only, decrement on pop-only, and remain unchanged otherwise; it SHALL never exceed DEPTH nor go below 0.
REQ-022 Pointer wrap from DEPTH-1 to 0 SHALL NOT corrupt the order or the count.
REQ-023 flush SHALL take priority over push and pop: on a flush edge, head, tail and count SHALL become 0, and any concurrent push or pop SHALL be discarded.
REQ-024 In the cycle after a flush, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-025 Without bypass, an entry pushed at edge N SHALL appear with out_valid = 1 in cycle N+1 (latency 1).
REQ-026 out_* SHALL hold stable while out_valid = 1 and out_ready = 0.

Reset
REQ-027 While rst = 1, head = tail = count = 0, out_valid = 0, in_ready = 0, and all storage fields SHALL be cleared to 0 (out_* read 0).
REQ-028 rst asserted mid-operation SHALL immediately discard all entries without waiting for a clock edge; operation SHALL resume on the first edge after deassertion.

Configuration
REQ-029 Macro IF_BUF_BYPASS_EN SHALL select the bypass path.
REQ-030 With IF_BUF_BYPASS_EN defined: when count = 0, in_valid = 1 and flush = 0, out_valid SHALL be 1 and out_* SHALL equal in_* combinationally. If out_ready = 1 in that cycle, the entry is consumed and NOT stored (count stays 0); otherwise it is pushed normally.
REQ-031 Without IF_BUF_BYPASS_EN: there SHALL be no combinational in_* to out_* path, and the minimum latency SHALL be 1 cycle.

Verification
REQ-032 Fill: DEPTH = 4, out_ready = 0, push PCs 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c -> count = 4, in_ready = 0, out_pc = 0x1c000000.
REQ-033 Full with pop: count = 4, in_valid = 1, out_ready = 1 for one edge -> pop only, count = 3, pending input not accepted; accepted on the next edge, count = 4.
REQ-034 Wrap: 10 entries streamed with alternating out_ready -> outputs in push order, with out_inst/out_pre_pc matching, and no loss across pointer wrap.
REQ-035 Flush: count = 3 while flush = 1 together with push and pop -> next cycle count = 0, out_valid = 0, in_ready = 1, and the pushed entry is absent.
REQ-036 Bypass: with IF_BUF_BYPASS_EN, empty buffer, in_valid = 1, out_ready = 1, in_inst = 0x02800000 -> same cycle out_valid = 1, out_inst = 0x02800000, count remains 0. Without the macro, out_valid = 0 in that cycle and rises in the next cycle.
REQ-037 Async reset: assert rst between edges with count = 2 -> count = 0, out_valid = 0, out_pc = 0 before the next edge.
